// File: rtl/sqm_vector_checker.sv
// Self-check engine for SQM: walks a synchronous-read vector ROM of {A,B,Yexp},
// drives A/B into SQM, compares SQM's Y and reports error count, first failure and pass.
module sqm_vector_checker #(
  parameter int A_W     = 8,
  parameter int B_W     = 4,
  parameter int Y_W     = 8,
  parameter int NUM_VEC = 10,
  parameter int ADDR_W  = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  output logic                     vec_rd_en,
  output logic [ADDR_W-1:0]        vec_addr,
  input  logic [A_W+B_W+Y_W-1:0]   vec_data,
  output logic [A_W-1:0]           dut_a,
  output logic [B_W-1:0]           dut_b,
  input  logic [Y_W-1:0]           dut_y,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [31:0]              error_count,
  output logic [31:0]              vec_count,
  output logic                     fail_pulse,
  output logic                     first_fail_valid,
  output logic [ADDR_W-1:0]        first_fail_idx,
  output logic [Y_W-1:0]           first_fail_got,
  output logic [Y_W-1:0]           first_fail_exp
);

  localparam int D_W = A_W + B_W + Y_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_VEC - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_APPLY, S_CHECK, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic [Y_W-1:0]    yexp_q, yexp_d;
  logic [A_W-1:0]    dut_a_q, dut_a_d;
  logic [B_W-1:0]    dut_b_q, dut_b_d;
  logic [31:0]       error_count_q, error_count_d;
  logic [31:0]       vec_count_q, vec_count_d;
  logic              fail_pulse_q, fail_pulse_d;
  logic              ff_valid_q, ff_valid_d;
  logic [ADDR_W-1:0] ff_idx_q, ff_idx_d;
  logic [Y_W-1:0]    ff_got_q, ff_got_d;
  logic [Y_W-1:0]    ff_exp_q, ff_exp_d;

  always_comb begin
    state_d       = state_q;
    index_d       = index_q;
    yexp_d        = yexp_q;
    dut_a_d       = dut_a_q;
    dut_b_d       = dut_b_q;
    error_count_d = error_count_q;
    vec_count_d   = vec_count_q;
    fail_pulse_d  = 1'b0;
    ff_valid_d    = ff_valid_q;
    ff_idx_d      = ff_idx_q;
    ff_got_d      = ff_got_q;
    ff_exp_d      = ff_exp_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        // abort is meaningless here, so start always wins
        if (start) begin
          error_count_d = '0;
          vec_count_d   = '0;
          ff_valid_d    = 1'b0;
          ff_idx_d      = '0;
          ff_got_d      = '0;
          ff_exp_d      = '0;
          index_d       = '0;
          state_d       = (NUM_VEC == 0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: state_d = abort ? S_IDLE : S_APPLY;
      S_APPLY: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          dut_a_d = vec_data[D_W-1 -: A_W];
          dut_b_d = vec_data[Y_W +: B_W];
          yexp_d  = vec_data[Y_W-1:0];
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          vec_count_d = vec_count_q + 32'd1;
          if (dut_y != yexp_q) begin
            fail_pulse_d = 1'b1;
            if (error_count_q != 32'hFFFF_FFFF) error_count_d = error_count_q + 32'd1;
            if (!ff_valid_q) begin
              ff_valid_d = 1'b1;
              ff_idx_d   = index_q;
              ff_got_d   = dut_y;
              ff_exp_d   = yexp_q;
            end
          end
          if (index_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            index_d = index_q + 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      index_q       <= '0;
      yexp_q        <= '0;
      dut_a_q       <= '0;
      dut_b_q       <= '0;
      error_count_q <= '0;
      vec_count_q   <= '0;
      fail_pulse_q  <= 1'b0;
      ff_valid_q    <= 1'b0;
      ff_idx_q      <= '0;
      ff_got_q      <= '0;
      ff_exp_q      <= '0;
    end else begin
      state_q       <= state_d;
      index_q       <= index_d;
      yexp_q        <= yexp_d;
      dut_a_q       <= dut_a_d;
      dut_b_q       <= dut_b_d;
      error_count_q <= error_count_d;
      vec_count_q   <= vec_count_d;
      fail_pulse_q  <= fail_pulse_d;
      ff_valid_q    <= ff_valid_d;
      ff_idx_q      <= ff_idx_d;
      ff_got_q      <= ff_got_d;
      ff_exp_q      <= ff_exp_d;
    end
  end

  assign vec_rd_en        = (state_q == S_FETCH);
  assign vec_addr         = index_q;
  assign dut_a            = dut_a_q;
  assign dut_b            = dut_b_q;
  assign busy             = (state_q == S_FETCH) || (state_q == S_APPLY) || (state_q == S_CHECK);
  assign done             = (state_q == S_DONE);
  assign pass             = (state_q == S_DONE) && (error_count_q == 32'd0);
  assign error_count      = error_count_q;
  assign vec_count        = vec_count_q;
  assign fail_pulse       = fail_pulse_q;
  assign first_fail_valid = ff_valid_q;
  assign first_fail_idx   = ff_idx_q;
  assign first_fail_got   = ff_got_q;
  assign first_fail_exp   = ff_exp_q;

endmodule

// File: tb/tb_sqm_vector_checker.sv
// Directed bench for sqm_vector_checker: a multiplier stands in for SQM, with
// per-A-value error masks to plant mismatches; a second instance covers NUM_VEC=0.
module tb_sqm_vector_checker;

  localparam int A_W = 8, B_W = 4, Y_W = 8, ADDR_W = 10;
  localparam int D_W = A_W + B_W + Y_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, start, abort;
  logic              vec_rd_en;
  logic [ADDR_W-1:0] vec_addr;
  logic [D_W-1:0]    vec_data;
  logic [A_W-1:0]    dut_a;
  logic [B_W-1:0]    dut_b;
  logic [Y_W-1:0]    dut_y;
  logic              busy, done, pass, fail_pulse, ff_valid;
  logic [31:0]       error_count, vec_count;
  logic [ADDR_W-1:0] ff_idx;
  logic [Y_W-1:0]    ff_got, ff_exp;

  logic              start0, rd_en0, busy0, done0, pass0, fp0, ffv0;
  logic [ADDR_W-1:0] addr0, ffi0;
  logic [D_W-1:0]    data0;
  logic [A_W-1:0]    a0;
  logic [B_W-1:0]    b0;
  logic [Y_W-1:0]    y0, ffg0, ffe0;
  logic [31:0]       ec0, vc0;

  // ROM contents with hand-computed Yexp = (A*B) mod 256
  logic [D_W-1:0] rom [10];
  initial begin
    rom[0] = {8'h05, 4'h1, 8'h05};
    rom[1] = {8'h0A, 4'h2, 8'h14};
    rom[2] = {8'h21, 4'h4, 8'h84};
    rom[3] = {8'h12, 4'h3, 8'h36};
    rom[4] = {8'h33, 4'h5, 8'hFF};
    rom[5] = {8'h47, 4'h6, 8'hAA};
    rom[6] = {8'h5C, 4'h7, 8'h84};
    rom[7] = {8'h60, 4'h8, 8'h00};
    rom[8] = {8'h7F, 4'h9, 8'h77};
    rom[9] = {8'hFF, 4'hF, 8'hF1};
  end

  always @(posedge clk) if (vec_rd_en) vec_data <= (vec_addr < 10) ? rom[vec_addr[3:0]] : '0;

  logic [7:0]  y_err [256];
  logic [11:0] prod;
  assign prod  = dut_a * dut_b;
  assign dut_y = prod[7:0] ^ y_err[dut_a];
  assign data0 = '0;
  assign y0    = '0;

  sqm_vector_checker #(.A_W(A_W), .B_W(B_W), .Y_W(Y_W), .NUM_VEC(10), .ADDR_W(ADDR_W)) u_dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .vec_rd_en(vec_rd_en), .vec_addr(vec_addr), .vec_data(vec_data),
    .dut_a(dut_a), .dut_b(dut_b), .dut_y(dut_y),
    .busy(busy), .done(done), .pass(pass),
    .error_count(error_count), .vec_count(vec_count), .fail_pulse(fail_pulse),
    .first_fail_valid(ff_valid), .first_fail_idx(ff_idx),
    .first_fail_got(ff_got), .first_fail_exp(ff_exp)
  );

  sqm_vector_checker #(.A_W(A_W), .B_W(B_W), .Y_W(Y_W), .NUM_VEC(0), .ADDR_W(ADDR_W)) u_dut0 (
    .clk(clk), .reset(reset), .start(start0), .abort(1'b0),
    .vec_rd_en(rd_en0), .vec_addr(addr0), .vec_data(data0),
    .dut_a(a0), .dut_b(b0), .dut_y(y0),
    .busy(busy0), .done(done0), .pass(pass0),
    .error_count(ec0), .vec_count(vc0), .fail_pulse(fp0),
    .first_fail_valid(ffv0), .first_fail_idx(ffi0),
    .first_fail_got(ffg0), .first_fail_exp(ffe0)
  );

  int vectors = 0;
  int miscompares = 0;
  int pulses = 0;
  int cyc = 0;
  bit rd0_seen = 1'b0;

  always @(negedge clk) begin
    if (fail_pulse === 1'b1) pulses++;
    if (rd_en0 === 1'b1) rd0_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Leaves the bench at the negedge inside cycle 1 (start sampled at edge 0)
  task automatic start_run();
    @(negedge clk);
    pulses = 0;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    cyc    = 1;
  endtask

  task automatic wait_done();
    while (done !== 1'b1 && cyc < 200) step(1);
    check("done_seen", 32'(done), 32'd1);
  endtask

  function automatic logic any_out();
    return |{busy, done, pass, error_count, vec_count, fail_pulse, ff_valid, ff_idx,
             ff_got, ff_exp, vec_rd_en, vec_addr, dut_a, dut_b};
  endfunction

  initial begin
    reset  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    start0 = 1'b0;
    for (int i = 0; i < 256; i++) y_err[i] = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'(any_out()), 32'd0);
    reset = 1'b1;

    // reset mid-run
    start_run();
    step(4);
    check("midrun_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("midrun_reset_outputs", 32'(any_out()), 32'd0);

    // all-pass run
    start_run();
    check("fetch0", {29'd0, vec_rd_en, busy, 1'b0} | 32'(vec_addr), 32'd6);
    wait_done();
    check("pass_done_cycle", cyc, 31);
    check("pass_pass", 32'(pass), 32'd1);
    check("pass_errors", error_count, 32'd0);
    check("pass_vec_count", vec_count, 32'd10);
    check("pass_pulses", pulses, 0);
    check("pass_ff_valid", 32'(ff_valid), 32'd0);
    check("pass_hold_ab", {20'd0, dut_a, dut_b}, 32'h0FFF);

    // single failure at vector 3
    y_err[8'h12] = 8'h03;
    for (int r = 0; r < 2; r++) begin
      start_run();
      check("run_cleared", {error_count[15:0], vec_count[15:0]}, 32'd0);
      check("run_cleared_ff", {30'd0, ff_valid, done}, 32'd0);
      wait_done();
      check("single_done_cycle", cyc, 31);
      check("single_errors", error_count, 32'd1);
      check("single_vec_count", vec_count, 32'd10);
      check("single_ff_valid", 32'(ff_valid), 32'd1);
      check("single_ff_idx", 32'(ff_idx), 32'd3);
      check("single_ff_got", 32'(ff_got), 32'h35);
      check("single_ff_exp", 32'(ff_exp), 32'h36);
      check("single_pulses", pulses, 1);
      check("single_pass", 32'(pass), 32'd0);
    end

    // mismatches at indices 2 and 7
    y_err[8'h12] = 8'h00;
    y_err[8'h21] = 8'h10;
    y_err[8'h60] = 8'h01;
    start_run();
    wait_done();
    check("multi_errors", error_count, 32'd2);
    check("multi_ff_idx", 32'(ff_idx), 32'd2);
    check("multi_ff_got", 32'(ff_got), 32'h94);
    check("multi_ff_exp", 32'(ff_exp), 32'h84);
    check("multi_pulses", pulses, 2);

    // abort in the CHECK cycle of mismatching vector 4
    y_err[8'h21] = 8'h00;
    y_err[8'h60] = 8'h00;
    y_err[8'h33] = 8'h01;
    start_run();
    step(14);
    check("abort_pre_vec_count", vec_count, 32'd4);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("abort_idle", {29'd0, busy, done, pass}, 32'd0);
    check("abort_vec_count", vec_count, 32'd4);
    check("abort_errors", error_count, 32'd0);
    check("abort_ff_valid", 32'(ff_valid), 32'd0);
    check("abort_pulses", pulses, 0);

    // start and abort together in IDLE: start wins
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    cyc   = 1;
    check("start_abort_busy", 32'(busy), 32'd1);
    wait_done();
    check("sa_errors", error_count, 32'd1);
    check("sa_ff_idx", 32'(ff_idx), 32'd4);
    check("sa_ff_got", 32'(ff_got), 32'hFE);
    check("sa_ff_exp", 32'(ff_exp), 32'hFF);

    // NUM_VEC = 0 build
    check("nv0_idle", 32'(done0), 32'd0);
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    check("nv0_done", 32'(done0), 32'd1);
    check("nv0_pass", 32'(pass0), 32'd1);
    check("nv0_busy", 32'(busy0), 32'd0);
    check("nv0_no_rd", 32'(rd0_seen), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
